// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: widths, ALUOp/Memoffset encodings, opcode constants
// and the packed control/payload bundles carried from ID into EX.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNTW = 16;
  localparam int unsigned REGW = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_R      = 2'b10,
    ALUOP_I      = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10,
    MEM_WORD = 2'b11
  } memoff_e;

  // opcode[6:2]
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       lui;
    logic       unsignedflag;
    logic [1:0] aluop;
    logic [1:0] memoffset;
  } ctrl_t;

  typedef struct packed {
    logic            valid;
    ctrl_t           ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [2:0]      funct3;
    logic            funct7b5;
  } ex_payload_t;

  // Clear decode bits that are meaningless for this instruction so EX never sees them.
  function automatic ctrl_t sanitize_ctrl(ctrl_t c, logic [REGW-1:0] rd);
    ctrl_t s;
    s          = c;
    s.memtoreg = c.memtoreg & c.memread;
    if (c.jal | c.jalr | c.lui | c.auipc) s.aluop = ALUOP_ADD;
    if (!(c.memread | c.memwrite)) begin
      s.unsignedflag = 1'b0;
      s.memoffset    = MEM_NONE;
    end
    if (rd == '0) s.regwrite = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX boundary bundle: decode-side inputs, EX-side registered copies, stall/flush and counters.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic                flush;
  logic                id_valid;
  ctrl_t               id_ctrl;
  logic [XLEN-1:0]     id_pc;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_imm;
  logic [REGW-1:0]     id_rs1;
  logic [REGW-1:0]     id_rs2;
  logic [REGW-1:0]     id_rd;
  logic [2:0]          id_funct3;
  logic                id_funct7b5;

  logic                stall;
  logic                ex_valid;
  ctrl_t               ex_ctrl;
  logic [XLEN-1:0]     ex_pc;
  logic [XLEN-1:0]     ex_rs1_data;
  logic [XLEN-1:0]     ex_rs2_data;
  logic [XLEN-1:0]     ex_imm;
  logic [REGW-1:0]     ex_rs1;
  logic [REGW-1:0]     ex_rs2;
  logic [REGW-1:0]     ex_rd;
  logic [2:0]          ex_funct3;
  logic                ex_funct7b5;
  logic [CNTW-1:0]     stall_count;
  logic [CNTW-1:0]     flush_count;

  modport master (
    output flush, id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    input  stall, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, stall_count, flush_count
  );

  modport slave (
    input  flush, id_valid, id_ctrl, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5,
    output stall, ex_valid, ex_ctrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the ID instruction reads a register a load in EX has not yet produced.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic            id_valid_i,
  input  logic            id_branch_i,
  input  logic            id_memwrite_i,
  input  logic            id_alusrc_i,
  input  logic            id_jal_i,
  input  logic            id_jalr_i,
  input  logic            id_lui_i,
  input  logic            id_auipc_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic            ex_valid_i,
  input  logic            ex_memread_i,
  input  logic [REGW-1:0] ex_rd_i,
  output logic            haz_o
);

  logic uses_rs1;
  logic uses_rs2;

  // Only compare source fields the instruction format actually reads.
  always_comb begin
    uses_rs1 = !(id_jal_i | id_lui_i | id_auipc_i);
    uses_rs2 = id_branch_i | id_memwrite_i |
               (!id_alusrc_i & !id_jal_i & !id_jalr_i & !id_lui_i & !id_auipc_i);
    haz_o    = id_valid_i & ex_valid_i & ex_memread_i & (ex_rd_i != '0) &
               ((uses_rs1 & (id_rs1_i == ex_rd_i)) | (uses_rs2 & (id_rs2_i == ex_rd_i)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion, EX-driven flush
// and saturating stall/flush event counters.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  logic            haz;
  ex_payload_t     ex_d, ex_q;
  logic [CNTW-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNTW-1:0] flush_cnt_d, flush_cnt_q;

  hazard_detect u_hazard_detect (
    .id_valid_i    (bus.id_valid),
    .id_branch_i   (bus.id_ctrl.branch),
    .id_memwrite_i (bus.id_ctrl.memwrite),
    .id_alusrc_i   (bus.id_ctrl.alusrc),
    .id_jal_i      (bus.id_ctrl.jal),
    .id_jalr_i     (bus.id_ctrl.jalr),
    .id_lui_i      (bus.id_ctrl.lui),
    .id_auipc_i    (bus.id_ctrl.auipc),
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .ex_valid_i    (ex_q.valid),
    .ex_memread_i  (ex_q.ctrl.memread),
    .ex_rd_i       (ex_q.rd),
    .haz_o         (haz)
  );

  // A flush already kills the ID instruction, so it never needs to be held.
  assign bus.stall = haz & !bus.flush & !rst;

  // Flush and hazard both leave the default all-zero bubble.
  always_comb begin
    ex_d        = '0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.flush && !haz && bus.id_valid) begin
      ex_d.valid    = 1'b1;
      ex_d.ctrl     = sanitize_ctrl(bus.id_ctrl, bus.id_rd);
      ex_d.pc       = bus.id_pc;
      ex_d.rs1_data = bus.id_rs1_data;
      ex_d.rs2_data = bus.id_rs2_data;
      ex_d.imm      = bus.id_imm;
      ex_d.rs1      = bus.id_rs1;
      ex_d.rs2      = bus.id_rs2;
      ex_d.rd       = bus.id_rd;
      ex_d.funct3   = bus.id_funct3;
      ex_d.funct7b5 = bus.id_funct7b5;
    end
    if (bus.stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
    if (bus.flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_ctrl     = ex_q.ctrl;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_funct7b5 = ex_q.funct7b5;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/sanitisation cases, then randomized
// traffic and a long flush run, all checked against an instruction-level model.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int CW   = $bits(ctrl_t);
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected contents of the EX stage and counters.
  logic            exp_valid;
  ctrl_t           exp_ctrl;
  logic [XLEN-1:0] exp_pc, exp_rs1d, exp_rs2d, exp_imm;
  logic [REGW-1:0] exp_rs1, exp_rs2, exp_rd;
  logic [2:0]      exp_f3;
  logic            exp_f7;
  int              exp_scnt, exp_fcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Does the instruction in ID need a value the load in EX has not delivered yet?
  function automatic logic model_haz();
    ctrl_t c;
    logic  reads1, reads2;
    c      = bus.id_ctrl;
    reads1 = !(c.jal || c.lui || c.auipc);
    reads2 = c.branch || c.memwrite || !(c.alusrc || c.jal || c.jalr || c.lui || c.auipc);
    return bus.id_valid && exp_valid && exp_ctrl.memread && (exp_rd != 0) &&
           ((reads1 && bus.id_rs1 == exp_rd) || (reads2 && bus.id_rs2 == exp_rd));
  endfunction

  task automatic model_bubble();
    exp_valid = 0; exp_ctrl = '0; exp_pc = '0; exp_rs1d = '0; exp_rs2d = '0; exp_imm = '0;
    exp_rs1 = '0; exp_rs2 = '0; exp_rd = '0; exp_f3 = '0; exp_f7 = 0;
  endtask

  task automatic model_edge();
    logic h;
    h = model_haz();
    if (rst) begin
      model_bubble();
      exp_scnt = 0;
      exp_fcnt = 0;
    end else begin
      if (bus.flush) exp_fcnt = (exp_fcnt < CMAX) ? exp_fcnt + 1 : CMAX;
      else if (h)    exp_scnt = (exp_scnt < CMAX) ? exp_scnt + 1 : CMAX;
      if (bus.flush || h || !bus.id_valid) model_bubble();
      else begin
        exp_valid = 1;
        exp_ctrl  = bus.id_ctrl;
        if (!bus.id_ctrl.memread) exp_ctrl.memtoreg = 0;
        if (bus.id_ctrl.jal || bus.id_ctrl.jalr || bus.id_ctrl.lui || bus.id_ctrl.auipc)
          exp_ctrl.aluop = 2'b00;
        if (!bus.id_ctrl.memread && !bus.id_ctrl.memwrite) begin
          exp_ctrl.unsignedflag = 0;
          exp_ctrl.memoffset    = 2'b00;
        end
        if (bus.id_rd == 0) exp_ctrl.regwrite = 0;
        exp_pc = bus.id_pc; exp_rs1d = bus.id_rs1_data; exp_rs2d = bus.id_rs2_data;
        exp_imm = bus.id_imm; exp_rs1 = bus.id_rs1; exp_rs2 = bus.id_rs2; exp_rd = bus.id_rd;
        exp_f3 = bus.id_funct3; exp_f7 = bus.id_funct7b5;
      end
    end
  endtask

  task automatic check_ex();
    chk("ex_valid", 64'(bus.ex_valid), 64'(exp_valid));
    chk("ex_ctrl", 64'(bus.ex_ctrl), 64'(exp_ctrl));
    chk("ex_pc", 64'(bus.ex_pc), 64'(exp_pc));
    chk("ex_rs1_data", 64'(bus.ex_rs1_data), 64'(exp_rs1d));
    chk("ex_rs2_data", 64'(bus.ex_rs2_data), 64'(exp_rs2d));
    chk("ex_imm", 64'(bus.ex_imm), 64'(exp_imm));
    chk("ex_idx", 64'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_funct3, bus.ex_funct7b5}),
        64'({exp_rs1, exp_rs2, exp_rd, exp_f3, exp_f7}));
    chk("stall_count", 64'(bus.stall_count), 64'(exp_scnt));
    chk("flush_count", 64'(bus.flush_count), 64'(exp_fcnt));
  endtask

  // Inputs are already applied; check stall, take one edge, check EX state.
  task automatic tick();
    logic s;
    #1;
    s = model_haz() && !bus.flush && !rst;
    chk("stall", 64'(bus.stall), 64'(s));
    @(posedge clk);
    model_edge();
    #1;
    check_ex();
  endtask

  task automatic clr_id();
    bus.flush = 0; bus.id_valid = 0; bus.id_ctrl = '0;
    bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_funct3 = '0; bus.id_funct7b5 = 0;
  endtask

  task automatic set_lw(input logic [REGW-1:0] rd);
    clr_id();
    bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_rs1 = 5'd1; bus.id_rd = rd;
    bus.id_ctrl.memread = 1; bus.id_ctrl.memtoreg = 1; bus.id_ctrl.alusrc = 1;
    bus.id_ctrl.regwrite = 1; bus.id_ctrl.memoffset = 2'b11; bus.id_funct3 = 3'b010;
  endtask

  task automatic set_add(input logic [REGW-1:0] rd, input logic [REGW-1:0] rs1,
                         input logic [REGW-1:0] rs2);
    clr_id();
    bus.id_valid = 1; bus.id_pc = 32'h104; bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.id_rs1_data = 32'h1111_2222; bus.id_rs2_data = 32'h3333_4444;
    bus.id_ctrl.regwrite = 1; bus.id_ctrl.aluop = 2'b10;
  endtask

  task automatic drive_rand();
    ctrl_t c;
    c = CW'($urandom);
    if ($urandom_range(0, 2) == 0) c.memread = 1;
    bus.id_valid    = ($urandom_range(0, 7) != 0);
    bus.id_ctrl     = c;
    bus.id_pc       = $urandom;
    bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;
    bus.id_imm      = $urandom;
    bus.id_rs1      = REGW'($urandom_range(0, 3));
    bus.id_rs2      = REGW'($urandom_range(0, 3));
    bus.id_rd       = REGW'($urandom_range(0, 3));
    bus.id_funct3   = 3'($urandom);
    bus.id_funct7b5 = 1'($urandom);
    bus.flush       = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    model_bubble(); exp_scnt = 0; exp_fcnt = 0;

    // Reset with every decode input high.
    rst = 1;
    bus.flush = 0; bus.id_valid = 1; bus.id_ctrl = '1;
    bus.id_pc = '1; bus.id_rs1_data = '1; bus.id_rs2_data = '1; bus.id_imm = '1;
    bus.id_rs1 = '1; bus.id_rs2 = '1; bus.id_rd = '1; bus.id_funct3 = '1; bus.id_funct7b5 = 1;
    tick(); tick();
    rst = 0;

    // Load-use: lw x5 then add x6,x5,x7.
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd7); tick();
    chk("lu_bubble", 64'(bus.ex_valid), 64'd0);
    chk("lu_scnt", 64'(bus.stall_count), 64'd1);
    tick();
    chk("lu_rd", 64'(bus.ex_rd), 64'd6);
    chk("lu_aluop", 64'(bus.ex_ctrl.aluop), 64'd2);

    // No dependency: addi reads only rs1, rs2 field happens to match.
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd0, 5'd5); bus.id_ctrl.alusrc = 1; bus.id_ctrl.aluop = 2'b11;
    bus.id_imm = 32'd4; tick();
    chk("addi_valid", 64'(bus.ex_valid), 64'd1);
    // Load to x0 never creates a hazard.
    set_lw(5'd0); tick();
    set_add(5'd6, 5'd0, 5'd9); tick();
    chk("x0_scnt", 64'(bus.stall_count), 64'd1);

    // Flush coinciding with a hazard.
    set_lw(5'd5); tick();
    set_add(5'd6, 5'd5, 5'd7); bus.flush = 1; tick();
    chk("fl_valid", 64'(bus.ex_valid), 64'd0);
    chk("fl_fcnt", 64'(bus.flush_count), 64'd1);
    chk("fl_scnt", 64'(bus.stall_count), 64'd1);

    // jal x1 with junk aluop/memtoreg.
    clr_id(); bus.id_valid = 1; bus.id_rd = 5'd1; bus.id_ctrl.jal = 1; bus.id_ctrl.regwrite = 1;
    bus.id_ctrl.aluop = 2'b11; bus.id_ctrl.memtoreg = 1; tick();
    chk("jal_ctrl", 64'({bus.ex_ctrl.jal, bus.ex_ctrl.aluop, bus.ex_ctrl.memtoreg,
                         bus.ex_ctrl.regwrite}), 64'(5'b1_00_0_1));

    // Hazard pending when reset hits: bubble discarded, counters cleared.
    set_lw(5'd3); tick();
    set_add(5'd4, 5'd3, 5'd3); rst = 1; tick();
    rst = 0; tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive_rand();
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 0;

    // Hold flush long enough to saturate the flush counter.
    for (int i = 0; i < CMAX + 4; i++) begin
      drive_rand();
      bus.flush = 1;
      tick();
    end
    chk("fcnt_sat", 64'(bus.flush_count), 64'(CMAX));
    bus.flush = 0; rst = 1; tick();
    chk("fcnt_clr", 64'(bus.flush_count), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
